// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch + data) arbiter in front of a
// synchronous single-port memory. Each access walks IDLE -> ISSUE (-> RESP for
// reads) -> IDLE, so the memory sees at most one command every two cycles.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   : round-robin between the ports on contention.
//   undefined : data port has fixed priority; fetch is guaranteed a grant
//               after STARVE_MAX consecutive contention losses.
//
// Handshake: a requester raises *_req with a stable command and holds it
// until it sees *_gnt (a one-cycle pulse in the cycle the command is on the
// memory bus). On the edge that ends the gnt cycle it drops *_req or replaces
// the command with a new one. Requests are only looked at in IDLE, and
// ISSUE/RESP always last one cycle, so a command is never issued twice.
// *_rvalid pulses for one cycle with *_rdata; *_rdata holds its last value
// otherwise.
module mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // instruction fetch port (read only)
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // memory side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // FSM state for observation: 0 = IDLE, 1 = ISSUE, 2 = RESP
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    logic          owner_d;     // 1 = data port owns the access in flight
    logic          we_q;        // access in flight is a write
    logic [DW-1:0] if_rdata_q;  // last fetch read data
    logic [DW-1:0] d_rdata_q;   // last data read data
    logic          any_req;
    logic          grant_d;     // arbitration result: 1 = data port wins

    assign any_req   = if_req | d_req;
    assign dbg_state = state;

    // Read data is passed straight from the memory during the rvalid cycle
    // (the memory output is only valid then) and held from a register after.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;

`ifdef MEM_ARB_RR_EN
    logic last_d;  // 1 = data port was granted most recently

    // Round-robin decision: the port not granted last wins on contention.
    always_comb begin
        grant_d = 1'b0;
        if (if_req && d_req) begin
            grant_d = ~last_d;
        end else begin
            grant_d = d_req;
        end
    end
`else
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt;  // consecutive fetch contention losses
    logic          starve_hit;

    assign starve_hit = (starve_cnt == CW'(STARVE_MAX));

    // Fixed-priority decision: data wins unless fetch has starved long enough.
    always_comb begin
        grant_d = 1'b0;
        if (d_req && !(if_req && starve_hit)) begin
            grant_d = 1'b1;
        end
    end
`endif

    // Main FSM: arbitration, command registers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_d     <= 1'b1;
`else
            starve_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d <= grant_d;
                        mem_en  <= 1'b1;
                        state   <= ISSUE;
                        if (grant_d) begin
                            we_q      <= d_we;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            d_gnt     <= 1'b1;
                        end else begin
                            // fetch is always a read
                            we_q      <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            if_gnt    <= 1'b1;
                        end
`ifdef MEM_ARB_RR_EN
                        last_d <= grant_d;
`else
                        if (!grant_d) begin
                            starve_cnt <= '0;
                        end else if (if_req) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
`endif
                    end
                end

                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if_gnt    <= 1'b0;
                    d_gnt     <= 1'b0;
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        state <= RESP;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rvalid <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    if_rvalid <= 1'b0;
                    d_rvalid  <= 1'b0;
                    if (owner_d) begin
                        d_rdata_q <= mem_rdata;
                    end else begin
                        if_rdata_q <= mem_rdata;
                    end
                    state <= IDLE;
                end

                default: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    if_gnt    <= 1'b0;
                    d_gnt     <= 1'b0;
                    if_rvalid <= 1'b0;
                    d_rvalid  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single-port transactions with
// hand-computed results, plus sequences for reset during RESP and for
// arbitration order under continuous contention.
module tb_mem_arbiter;

    localparam int AW         = 8;
    localparam int DW         = 8;
    localparam int STARVE_MAX = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    // expected read-data hold values of each port
    logic [DW-1:0] exp_if_rd;
    logic [DW-1:0] exp_d_rd;

    // expected grant owners under contention (1 = data)
    logic [0:0] exp_q[$];

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:255];
    logic          mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h66;
            mem[8'h10] = 8'hA5;
            mem_init   = 1'b0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_en"},    32'(mem_en),    0);
        check({tag, "_mem_we"},    32'(mem_we),    0);
        check({tag, "_gnts"},      32'({if_gnt, d_gnt}), 0);
        check({tag, "_rvalids"},   32'({if_rvalid, d_rvalid}), 0);
        check({tag, "_state"},     32'(dbg_state), 0);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        logic  rd;
        t  = $sformatf("v%0d", idx);
        rd = !v.we;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        // ISSUE cycle
        check({t, "_if_gnt"},   32'(if_gnt), 32'(!v.is_d));
        check({t, "_d_gnt"},    32'(d_gnt),  32'(v.is_d));
        check({t, "_mem_en"},   32'(mem_en), 1);
        check({t, "_mem_we"},   32'(mem_we), 32'(v.we));
        check({t, "_mem_addr"}, 32'(mem_addr), 32'(v.addr));
        if (v.we) check({t, "_mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
        check({t, "_state_issue"}, 32'(dbg_state), 1);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        // RESP cycle for reads, IDLE for writes
        check({t, "_mem_en_off"}, 32'(mem_en), 0);
        check({t, "_gnt_off"},    32'({if_gnt, d_gnt}), 0);
        check({t, "_if_rvalid"},  32'(if_rvalid), 32'(rd && !v.is_d));
        check({t, "_d_rvalid"},   32'(d_rvalid),  32'(rd && v.is_d));
        if (rd) begin
            if (v.is_d) exp_d_rd  = v.exp_rdata;
            else        exp_if_rd = v.exp_rdata;
        end
        check({t, "_if_rdata"}, 32'(if_rdata), 32'(exp_if_rd));
        check({t, "_d_rdata"},  32'(d_rdata),  32'(exp_d_rd));
        @(negedge clk);
        // back in IDLE; read data must be held
        check_idle_outputs({t, "_after"});
        check({t, "_if_rdata_hold"}, 32'(if_rdata), 32'(exp_if_rd));
        check({t, "_d_rdata_hold"},  32'(d_rdata),  32'(exp_d_rd));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_if_rd = '0;
        exp_d_rd  = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   grants;
        int   cyc;
        logic quiet_bad;

        // directed transactions; memory starts as mem[i] = i ^ 0x66, mem[0x10] = 0xA5
        vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
        vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h3C, exp_rdata: 8'h00};
        vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[3] = '{is_d: 1'b1, we: 1'b1, addr: 8'h10, wdata: 8'h5A, exp_rdata: 8'h00};
        vecs[4] = '{is_d: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'h5A};
        vecs[5] = '{is_d: 1'b1, we: 1'b1, addr: 8'hFF, wdata: 8'hC3, exp_rdata: 8'h00};
        vecs[6] = '{is_d: 1'b0, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'hC3};
        vecs[7] = '{is_d: 1'b1, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h66};
        vecs[8] = '{is_d: 1'b0, we: 1'b0, addr: 8'h01, wdata: 8'h00, exp_rdata: 8'h67};

        mem_init  = 1'b1;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        exp_if_rd = '0;
        exp_d_rd  = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_mem_addr",  32'(mem_addr),  0);
        check("reset_mem_wdata", 32'(mem_wdata), 0);
        check("reset_if_rdata",  32'(if_rdata),  0);
        check("reset_d_rdata",   32'(d_rdata),   0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // table-driven single-port transactions
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // reset during RESP of a fetch read (mem[0x10] now 0x5A)
        if_req  = 1'b1;
        if_addr = 8'h10;
        @(negedge clk);
        check("rst_if_gnt", 32'(if_gnt), 1);
        if_req = 1'b0;
        @(negedge clk);
        check("rst_resp_rvalid", 32'(if_rvalid), 1);
        check("rst_resp_rdata",  32'(if_rdata),  32'h5A);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        check("rst_async_if_rdata", 32'(if_rdata), 0);
        check("rst_async_d_rdata",  32'(d_rdata),  0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_if_rd = '0;
        exp_d_rd  = '0;
        quiet_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt || if_rvalid || d_rvalid || mem_en) quiet_bad = 1'b1;
        end
        check("rst_release_quiet", 32'(quiet_bad), 0);
        run_vec(vecs[8], 9);

        // continuous contention from a fresh reset
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_q.push_back(1'((i % 2) == 1));
`else
            exp_q.push_back(1'((i % (STARVE_MAX + 1)) != STARVE_MAX));
`endif
        end
        if_req  = 1'b1;
        if_addr = 8'h10;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 8'h20;
        grants  = 0;
        cyc     = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (if_gnt || d_gnt) begin
                check($sformatf("contend_one_gnt_%0d", grants), 32'(if_gnt && d_gnt), 0);
                check($sformatf("contend_order_%0d", grants), 32'(d_gnt), 32'(exp_q.pop_front()));
                grants++;
            end
        end
        check("contend_timeout", 32'(exp_q.size()), 0);
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
